// File: rtl/fsu_bitstream_gen_if.sv
// rtl/fsu_bitstream_gen_if.sv - operand handshake and bitstream output bundle for fsu_bitstream_gen
interface fsu_bitstream_gen_if #(
    parameter int IDIM = 8,
    parameter int IWID = 8
);
    logic            iValid;
    logic            iReady;
    logic [IWID-1:0] iData [IDIM-1:0];
    logic            iHold;
    logic            oBit  [IDIM-1:0];
    logic            oValid;
    logic            oLast;

    modport master (
        output iValid, iData, iHold,
        input  iReady, oBit, oValid, oLast
    );

    modport slave (
        input  iValid, iData, iHold,
        output iReady, oBit, oValid, oLast
    );
endinterface

// File: rtl/fsu_bitstream_gen.sv
// rtl/fsu_bitstream_gen.sv - multi-channel unary bitstream generator with bit-reversed counter RNG
module fsu_bitstream_gen #(
    parameter int IDIM = 8,
    parameter int IWID = 8,
    parameter int PHAS = 0
) (
    input  logic               clk,
    input  logic               rst,
    fsu_bitstream_gen_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IWID-1:0] cnt_q, cnt_d;
    logic [IWID-1:0] dreg_q [IDIM];
    logic [IWID-1:0] dreg_d [IDIM];
    logic            last;
    logic            ready;
    logic            xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < IDIM; i++) begin
                dreg_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < IDIM; i++) begin
                dreg_q[i] <= dreg_d[i];
            end
        end
    end

    // A new operand set is only taken when idle or on an unheld final bit,
    // which gives back-to-back periods without a bubble.
    always_comb begin
        last    = (state_q == RUN) && (cnt_q == {IWID{1'b1}});
        ready   = !rst && ((state_q == IDLE) || (last && !bus.iHold));
        xfer    = bus.iValid && ready;
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < IDIM; i++) begin
            dreg_d[i] = dreg_q[i];
        end
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    for (int i = 0; i < IDIM; i++) begin
                        dreg_d[i] = bus.iData[i];
                    end
                end
            end
            RUN: begin
                if (!bus.iHold) begin
                    if (!last) begin
                        cnt_d = cnt_q + IWID'(1);
                    end else if (xfer) begin
                        cnt_d = '0;
                        for (int i = 0; i < IDIM; i++) begin
                            dreg_d[i] = bus.iData[i];
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Channel phase offsets permute the period, so ones-per-period stays exact.
    always_comb begin
        logic [IWID-1:0] sum;
        logic [IWID-1:0] rng;
        bus.oValid = (state_q == RUN);
        bus.oLast  = last;
        bus.iReady = ready;
        sum = '0;
        rng = '0;
        for (int i = 0; i < IDIM; i++) begin
            sum = cnt_q + IWID'(i * PHAS);
            for (int b = 0; b < IWID; b++) begin
                rng[b] = sum[IWID-1-b];
            end
            bus.oBit[i] = (state_q == RUN) && (dreg_q[i] > rng);
        end
    end
endmodule
